// File: rtl/toy_bus_pkg.sv
// Shared toy bus definitions: payload widths,
// request/ack bundles and the two-way grant type.
package toy_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int STRB_W = 32;
  localparam int DATA_W = 256;
  localparam int ID_W   = 4;
  localparam int SB_W   = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] strb;
    logic [DATA_W-1:0] data;
    logic              opcode;
    logic [ID_W-1:0]   src_id;
    logic [ID_W-1:0]   tgt_id;
    logic [SB_W-1:0]   sideband;
  } ToyBusReq;

  typedef struct packed {
    logic              opcode;
    logic [DATA_W-1:0] data;
    logic [SB_W-1:0]   sideband;
    logic [ID_W-1:0]   src_id;
    logic [ID_W-1:0]   tgt_id;
  } ToyBusAck;

  typedef enum logic {
    GNT_IN0 = 1'b0,
    GNT_IN1 = 1'b1
  } gnt_e;

endpackage

// File: rtl/toy_bus_rr_arb2.sv
// Two-input round-robin arbiter with grant lock while stalled.
// Ports: clk, rst_n, i_elig[1:0], i_rdy -> o_gnt, o_vld.
module toy_bus_rr_arb2
  import toy_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_elig,
  input  logic       i_rdy,
  output gnt_e       o_gnt,
  output logic       o_vld
);

  gnt_e r_ptr;
  gnt_e r_gnt;
  logic r_lock;
  gnt_e w_gnt;

  // A stalled grant is held; otherwise the pointer
  // only decides when both inputs compete.
  always_comb begin
    w_gnt = GNT_IN0;
    if (r_lock)
      w_gnt = r_gnt;
    else if (&i_elig)
      w_gnt = r_ptr;
    else if (i_elig[1])
      w_gnt = GNT_IN1;
  end

  assign o_gnt = w_gnt;
  assign o_vld = (w_gnt == GNT_IN1) ?
                 i_elig[1] : i_elig[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= GNT_IN0;
      r_gnt  <= GNT_IN0;
      r_lock <= 1'b0;
    end else begin
      r_lock <= o_vld & ~i_rdy;
      if (o_vld)
        r_gnt <= w_gnt;
      if (o_vld && i_rdy)
        r_ptr <= (w_gnt == GNT_IN0) ?
                 GNT_IN1 : GNT_IN0;
    end
  end

endmodule

// File: rtl/toy_bus_arb2ch_req_dec_ack.sv
// Two initiators merged onto one target; acks decoded back by tgt_id.
// Ports: in0/in1 req+ack channels, out0 req+ack channels, err_ack.
module toy_bus_arb2ch_req_dec_ack
  import toy_bus_pkg::*;
#(
  parameter logic [ID_W-1:0] IN0_ID  = 4'd0,
  parameter logic [ID_W-1:0] IN1_ID  = 4'd1,
  parameter int              MAX_OST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_req_vld,
  output logic              in0_req_rdy,
  input  logic [ADDR_W-1:0] in0_req_addr,
  input  logic [STRB_W-1:0] in0_req_strb,
  input  logic [DATA_W-1:0] in0_req_data,
  input  logic              in0_req_opcode,
  input  logic [ID_W-1:0]   in0_req_src_id,
  input  logic [ID_W-1:0]   in0_req_tgt_id,
  input  logic [SB_W-1:0]   in0_req_sideband,
  output logic              in0_ack_vld,
  input  logic              in0_ack_rdy,
  output logic              in0_ack_opcode,
  output logic [DATA_W-1:0] in0_ack_data,
  output logic [SB_W-1:0]   in0_ack_sideband,
  output logic [ID_W-1:0]   in0_ack_src_id,
  output logic [ID_W-1:0]   in0_ack_tgt_id,
  input  logic              in1_req_vld,
  output logic              in1_req_rdy,
  input  logic [ADDR_W-1:0] in1_req_addr,
  input  logic [STRB_W-1:0] in1_req_strb,
  input  logic [DATA_W-1:0] in1_req_data,
  input  logic              in1_req_opcode,
  input  logic [ID_W-1:0]   in1_req_src_id,
  input  logic [ID_W-1:0]   in1_req_tgt_id,
  input  logic [SB_W-1:0]   in1_req_sideband,
  output logic              in1_ack_vld,
  input  logic              in1_ack_rdy,
  output logic              in1_ack_opcode,
  output logic [DATA_W-1:0] in1_ack_data,
  output logic [SB_W-1:0]   in1_ack_sideband,
  output logic [ID_W-1:0]   in1_ack_src_id,
  output logic [ID_W-1:0]   in1_ack_tgt_id,
  output logic              out0_req_vld,
  input  logic              out0_req_rdy,
  output logic [ADDR_W-1:0] out0_req_addr,
  output logic [STRB_W-1:0] out0_req_strb,
  output logic [DATA_W-1:0] out0_req_data,
  output logic              out0_req_opcode,
  output logic [ID_W-1:0]   out0_req_src_id,
  output logic [ID_W-1:0]   out0_req_tgt_id,
  output logic [SB_W-1:0]   out0_req_sideband,
  input  logic              out0_ack_vld,
  output logic              out0_ack_rdy,
  input  logic              out0_ack_opcode,
  input  logic [DATA_W-1:0] out0_ack_data,
  input  logic [SB_W-1:0]   out0_ack_sideband,
  input  logic [ID_W-1:0]   out0_ack_src_id,
  input  logic [ID_W-1:0]   out0_ack_tgt_id,
  output logic              err_ack
);

  localparam logic [2:0] MAX_C = 3'(MAX_OST);

  logic [2:0] r_ost [2];
  ToyBusReq   w_req0;
  ToyBusReq   w_req1;
  ToyBusReq   w_req;
  ToyBusAck   w_ack;
  gnt_e       w_gnt;
  logic       w_gvld;
  logic [1:0] w_elig;
  logic [1:0] w_req_x;
  logic [1:0] w_ack_x;
  logic [1:0] w_zero;
  logic       w_hit0;
  logic       w_hit1;

  assign w_req0 = '{addr: in0_req_addr,
                    strb: in0_req_strb,
                    data: in0_req_data,
                    opcode: in0_req_opcode,
                    src_id: in0_req_src_id,
                    tgt_id: in0_req_tgt_id,
                    sideband: in0_req_sideband};
  assign w_req1 = '{addr: in1_req_addr,
                    strb: in1_req_strb,
                    data: in1_req_data,
                    opcode: in1_req_opcode,
                    src_id: in1_req_src_id,
                    tgt_id: in1_req_tgt_id,
                    sideband: in1_req_sideband};

  // Eligibility uses the registered count, so an ack
  // freeing a slot only helps from the next cycle.
  assign w_elig[0] = in0_req_vld & (r_ost[0] < MAX_C);
  assign w_elig[1] = in1_req_vld & (r_ost[1] < MAX_C);

  toy_bus_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_elig (w_elig),
    .i_rdy  (out0_req_rdy),
    .o_gnt  (w_gnt),
    .o_vld  (w_gvld)
  );

  assign w_req = (w_gnt == GNT_IN1) ? w_req1 : w_req0;

  assign out0_req_vld      = rst_n & w_gvld;
  assign out0_req_addr     = w_req.addr;
  assign out0_req_strb     = w_req.strb;
  assign out0_req_data     = w_req.data;
  assign out0_req_opcode   = w_req.opcode;
  assign out0_req_src_id   = w_req.src_id;
  assign out0_req_tgt_id   = w_req.tgt_id;
  assign out0_req_sideband = w_req.sideband;

  assign in0_req_rdy = out0_req_vld & out0_req_rdy &
                       (w_gnt == GNT_IN0);
  assign in1_req_rdy = out0_req_vld & out0_req_rdy &
                       (w_gnt == GNT_IN1);

  assign w_ack = '{opcode: out0_ack_opcode,
                   data: out0_ack_data,
                   sideband: out0_ack_sideband,
                   src_id: out0_ack_src_id,
                   tgt_id: out0_ack_tgt_id};

  assign w_hit0 = (out0_ack_tgt_id == IN0_ID);
  assign w_hit1 = ~w_hit0 & (out0_ack_tgt_id == IN1_ID);

  assign in0_ack_vld = rst_n & out0_ack_vld & w_hit0;
  assign in1_ack_vld = rst_n & out0_ack_vld & w_hit1;

  // Unroutable acks are swallowed so the target never stalls.
  assign out0_ack_rdy = rst_n & (w_hit0 ? in0_ack_rdy :
                                 w_hit1 ? in1_ack_rdy : 1'b1);

  assign in0_ack_opcode   = w_ack.opcode;
  assign in0_ack_data     = w_ack.data;
  assign in0_ack_sideband = w_ack.sideband;
  assign in0_ack_src_id   = w_ack.src_id;
  assign in0_ack_tgt_id   = w_ack.tgt_id;
  assign in1_ack_opcode   = w_ack.opcode;
  assign in1_ack_data     = w_ack.data;
  assign in1_ack_sideband = w_ack.sideband;
  assign in1_ack_src_id   = w_ack.src_id;
  assign in1_ack_tgt_id   = w_ack.tgt_id;

  assign w_req_x = {in1_req_vld & in1_req_rdy,
                    in0_req_vld & in0_req_rdy};
  assign w_ack_x = {in1_ack_vld & in1_ack_rdy,
                    in0_ack_vld & in0_ack_rdy};
  assign w_zero  = {r_ost[1] == 3'd0, r_ost[0] == 3'd0};

  assign err_ack = rst_n &
                   ((out0_ack_vld & ~w_hit0 & ~w_hit1) |
                    (|(w_ack_x & w_zero)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ost[0] <= 3'd0;
      r_ost[1] <= 3'd0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        case ({w_req_x[n], w_ack_x[n]})
          2'b10: r_ost[n] <= r_ost[n] + 3'd1;
          2'b01: if (!w_zero[n])
                   r_ost[n] <= r_ost[n] - 3'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_toy_bus_arb2ch_req_dec_ack.sv
// Directed bench with an outstanding-count model and per-cycle checks.
// Drives both initiators and the target ack channel.
module tb_toy_bus_arb2ch_req_dec_ack;

  localparam int MAXO = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         v0, v1, oq_rdy;
  logic [255:0] d0, d1;
  logic         ak_vld, ak_op, ar0, ar1;
  logic [3:0]   ak_tgt, ak_src;
  logic [255:0] ak_data;
  logic [31:0]  ak_sb;

  logic         in0_req_rdy, in1_req_rdy;
  logic         in0_ack_vld, in1_ack_vld;
  logic         in0_ack_opcode, in1_ack_opcode;
  logic [255:0] in0_ack_data, in1_ack_data;
  logic [31:0]  in0_ack_sideband, in1_ack_sideband;
  logic [3:0]   in0_ack_src_id, in1_ack_src_id;
  logic [3:0]   in0_ack_tgt_id, in1_ack_tgt_id;
  logic         out0_req_vld, out0_req_opcode;
  logic [31:0]  out0_req_addr, out0_req_strb, out0_req_sideband;
  logic [255:0] out0_req_data;
  logic [3:0]   out0_req_src_id, out0_req_tgt_id;
  logic         out0_ack_rdy, err_ack;

  toy_bus_arb2ch_req_dec_ack #(
    .IN0_ID(4'd0), .IN1_ID(4'd1), .MAX_OST(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_req_vld(v0), .in0_req_rdy(in0_req_rdy),
    .in0_req_addr(32'hA0), .in0_req_strb(32'hFFFF_FFFF),
    .in0_req_data(d0), .in0_req_opcode(1'b0),
    .in0_req_src_id(4'hA), .in0_req_tgt_id(4'h3),
    .in0_req_sideband(32'h0A0A),
    .in0_ack_vld(in0_ack_vld), .in0_ack_rdy(ar0),
    .in0_ack_opcode(in0_ack_opcode), .in0_ack_data(in0_ack_data),
    .in0_ack_sideband(in0_ack_sideband),
    .in0_ack_src_id(in0_ack_src_id), .in0_ack_tgt_id(in0_ack_tgt_id),
    .in1_req_vld(v1), .in1_req_rdy(in1_req_rdy),
    .in1_req_addr(32'hB0), .in1_req_strb(32'h0000_FFFF),
    .in1_req_data(d1), .in1_req_opcode(1'b1),
    .in1_req_src_id(4'hB), .in1_req_tgt_id(4'h3),
    .in1_req_sideband(32'h0B0B),
    .in1_ack_vld(in1_ack_vld), .in1_ack_rdy(ar1),
    .in1_ack_opcode(in1_ack_opcode), .in1_ack_data(in1_ack_data),
    .in1_ack_sideband(in1_ack_sideband),
    .in1_ack_src_id(in1_ack_src_id), .in1_ack_tgt_id(in1_ack_tgt_id),
    .out0_req_vld(out0_req_vld), .out0_req_rdy(oq_rdy),
    .out0_req_addr(out0_req_addr), .out0_req_strb(out0_req_strb),
    .out0_req_data(out0_req_data), .out0_req_opcode(out0_req_opcode),
    .out0_req_src_id(out0_req_src_id), .out0_req_tgt_id(out0_req_tgt_id),
    .out0_req_sideband(out0_req_sideband),
    .out0_ack_vld(ak_vld), .out0_ack_rdy(out0_ack_rdy),
    .out0_ack_opcode(ak_op), .out0_ack_data(ak_data),
    .out0_ack_sideband(ak_sb), .out0_ack_src_id(ak_src),
    .out0_ack_tgt_id(ak_tgt),
    .err_ack(err_ack)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Model: who should win, how many requests each side has
  // outstanding, and which side is stuck waiting on the target.
  int   m_pref, m_hold;
  int   m_ost [2];
  int   e_win, e_route;
  logic el0, el1, e_vld, e_r0, e_r1;
  logic e_av0, e_av1, e_ardy, e_err, e_unexp;

  always_comb begin
    el0 = v0 && (m_ost[0] < MAXO);
    el1 = v1 && (m_ost[1] < MAXO);
    if (m_hold >= 0)       e_win = m_hold;
    else if (el0 && el1)   e_win = m_pref;
    else if (el0)          e_win = 0;
    else if (el1)          e_win = 1;
    else                   e_win = -1;
    e_vld = rst_n && (e_win >= 0) && ((e_win == 0) ? v0 : v1);
    e_r0  = e_vld && oq_rdy && (e_win == 0);
    e_r1  = e_vld && oq_rdy && (e_win == 1);
    e_route = (ak_tgt == 4'd0) ? 0 : (ak_tgt == 4'd1) ? 1 : -1;
    e_av0 = rst_n && ak_vld && (e_route == 0);
    e_av1 = rst_n && ak_vld && (e_route == 1);
    e_ardy = rst_n && ((e_route < 0) ? 1'b1 :
                       (e_route == 0) ? ar0 : ar1);
    e_unexp = (e_av0 && ar0 && m_ost[0] == 0) ||
              (e_av1 && ar1 && m_ost[1] == 0);
    e_err = rst_n && ak_vld && ((e_route < 0) || e_unexp);
  end

  function automatic int upd(int c, logic inc, logic dec);
    int r;
    r = c + int'(inc) - int'(dec);
    return (r < 0) ? 0 : r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pref   <= 0;
      m_hold   <= -1;
      m_ost[0] <= 0;
      m_ost[1] <= 0;
    end else begin
      if (e_vld && oq_rdy) begin
        m_pref <= 1 - e_win;
        m_hold <= -1;
      end else if (e_vld) m_hold <= e_win;
      else m_hold <= -1;
      m_ost[0] <= upd(m_ost[0], e_r0, e_av0 && ar0);
      m_ost[1] <= upd(m_ost[1], e_r1, e_av1 && ar1);
    end
  end

  always @(negedge clk) begin
    chk("ctl",
        128'({out0_req_vld, in0_req_rdy, in1_req_rdy, in0_ack_vld,
              in1_ack_vld, out0_ack_rdy, err_ack}),
        128'({e_vld, e_r0, e_r1, e_av0, e_av1, e_ardy, e_err}));
    if (e_vld)
      chk("req_pay",
          128'({out0_req_src_id, out0_req_data[63:0], out0_req_addr}),
          (e_win == 0) ? 128'({4'hA, d0[63:0], 32'hA0})
                       : 128'({4'hB, d1[63:0], 32'hB0}));
    if (e_av0)
      chk("ack0_pay",
          128'({in0_ack_src_id, in0_ack_data[63:0], in0_ack_sideband}),
          128'({ak_src, ak_data[63:0], ak_sb}));
    if (e_av1)
      chk("ack1_pay",
          128'({in1_ack_src_id, in1_ack_data[63:0], in1_ack_sideband}),
          128'({ak_src, ak_data[63:0], ak_sb}));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; v0 = 1'b1; v1 = 1'b0; oq_rdy = 1'b1;
    d0 = {8{32'hA5A5_0001}}; d1 = {8{32'h5A5A_0002}};
    ak_vld = 1'b1; ak_tgt = 4'hF; ak_op = 1'b1; ar0 = 1'b1; ar1 = 1'b1;
    ak_src = 4'h7; ak_data = {8{32'hC0DE_0003}}; ak_sb = 32'h5B;
    #2;
    chk("rst_outs",
        128'({out0_req_vld, in0_req_rdy, in1_req_rdy, in0_ack_vld,
              in1_ack_vld, out0_ack_rdy, err_ack}), 128'(0));
    cyc(); cyc();
    rst_n = 1'b1; v0 = 1'b0; ak_vld = 1'b0;

    // alternating grants with prompt acks
    cyc(); v0 = 1'b1; v1 = 1'b1; #1;
    chk("rr_c1", 128'(out0_req_src_id), 128'(4'hA));
    cyc(); ak_vld = 1'b1; ak_tgt = 4'd0; #1;
    chk("rr_c2", 128'(out0_req_src_id), 128'(4'hB));
    cyc(); ak_tgt = 4'd1; #1;
    chk("rr_c3", 128'(out0_req_src_id), 128'(4'hA));
    cyc(); ak_tgt = 4'd0; #1;
    chk("rr_c4", 128'(out0_req_src_id), 128'(4'hB));
    cyc(); v0 = 1'b0; v1 = 1'b0; ak_tgt = 4'd1;
    cyc(); ak_vld = 1'b0;

    // grant lock while target stalls
    cyc(); oq_rdy = 1'b0; v0 = 1'b1; #1;
    chk("lk_c1", 128'({out0_req_vld, out0_req_src_id}), 128'({1'b1, 4'hA}));
    cyc(); v1 = 1'b1; #1;
    chk("lk_c2", 128'(out0_req_src_id), 128'(4'hA));
    cyc(); #1;
    chk("lk_c3", 128'({out0_req_src_id, out0_req_data}),
        128'({4'hA, d0[123:0]}));
    cyc(); oq_rdy = 1'b1; #1;
    chk("lk_c4", 128'({in0_req_rdy, in1_req_rdy}), 128'(2'b10));
    cyc(); d0 = {8{32'hA5A5_0009}}; #1;
    chk("lk_c5", 128'({in0_req_rdy, in1_req_rdy}), 128'(2'b01));
    cyc(); v0 = 1'b0; v1 = 1'b0; ak_vld = 1'b1; ak_tgt = 4'd0;
    cyc(); ak_tgt = 4'd1;
    cyc(); ak_vld = 1'b0;

    // outstanding limit on in0
    cyc(); v0 = 1'b1; #1;
    chk("ost_c1", 128'(in0_req_rdy), 128'(1));
    cyc(); #1;
    chk("ost_c2", 128'(in0_req_rdy), 128'(1));
    cyc(); v1 = 1'b1; #1;
    chk("ost_c3", 128'({in0_req_rdy, in1_req_rdy}), 128'(2'b01));
    cyc(); v1 = 1'b0; ak_vld = 1'b1; ak_tgt = 4'd0; #1;
    chk("ost_c4", 128'({in0_req_rdy, out0_ack_rdy}), 128'(2'b01));
    cyc(); ak_vld = 1'b0; #1;
    chk("ost_c5", 128'(in0_req_rdy), 128'(1));
    cyc(); v0 = 1'b0; ak_vld = 1'b1; ak_tgt = 4'd0;
    cyc();
    cyc(); ak_tgt = 4'd1;
    cyc(); ak_vld = 1'b0;

    // ack backpressure from in1
    cyc(); ak_vld = 1'b1; ak_tgt = 4'd1; ar1 = 1'b0; #1;
    chk("bp_c1", 128'({out0_ack_rdy, in0_ack_vld, in1_ack_vld}),
        128'(3'b001));
    cyc(); #1;
    chk("bp_c2", 128'(out0_ack_rdy), 128'(0));
    cyc(); ar1 = 1'b1; #1;
    chk("bp_c3", 128'({out0_ack_rdy, in0_ack_vld, err_ack}),
        128'(3'b101));
    cyc(); ak_vld = 1'b0;

    // unroutable and unexpected acks
    cyc(); ak_vld = 1'b1; ak_tgt = 4'hF; #1;
    chk("bad_id", 128'({out0_ack_rdy, err_ack, in0_ack_vld, in1_ack_vld}),
        128'(4'b1100));
    cyc(); ak_vld = 1'b0; #1;
    chk("err_gone", 128'(err_ack), 128'(0));
    cyc(); ak_vld = 1'b1; ak_tgt = 4'd0; #1;
    chk("unexp0", 128'({in0_ack_vld, err_ack}), 128'(2'b11));
    cyc(); ak_vld = 1'b0;

    // reset while locked
    cyc(); v0 = 1'b1; oq_rdy = 1'b1;
    cyc(); v0 = 1'b0; v1 = 1'b1; oq_rdy = 1'b0; #1;
    chk("pre_rst", 128'(out0_req_src_id), 128'(4'hB));
    cyc(); #2; rst_n = 1'b0; #1;
    chk("mid_rst",
        128'({out0_req_vld, in0_req_rdy, in1_req_rdy, in0_ack_vld,
              in1_ack_vld, out0_ack_rdy, err_ack}), 128'(0));
    cyc(); cyc();
    rst_n = 1'b1; v1 = 1'b0; ak_vld = 1'b1; ak_tgt = 4'd0; #1;
    chk("post_cnt", 128'({in0_ack_vld, err_ack}), 128'(2'b11));
    cyc(); ak_vld = 1'b0; v0 = 1'b1; v1 = 1'b1; oq_rdy = 1'b1; #1;
    chk("post_ptr", 128'({in0_req_rdy, in1_req_rdy}), 128'(2'b10));
    cyc(); v0 = 1'b0; v1 = 1'b0;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
